bht_gshare_predictor: RTL and testbench

//   Parametrised successor to the single-counter predictor: a table of ENTRIES saturating

---
 rtl/bht_gshare_predictor.sv | 98 +++++++++
 tb/tb_bht_gshare_predictor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_gshare_predictor.sv
// Branch history table of saturating counters, optionally gshare-indexed.
// Combinational IF-stage prediction, non-speculative MEM-stage training.
module bht_gshare_predictor #(
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int INDEX_LSB = 2,
    parameter int GSHARE    = 0,
    parameter int GHR_BITS  = 4,
    parameter int RESET_CTR = 2**(CTR_BITS-1)-1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         pc_IF,
    output logic                branch_predict,
    output logic [GHR_BITS-1:0] ghr_IF,
    input  logic                update_valid_MEM,
    input  logic [63:0]         pc_MEM,
    input  logic [GHR_BITS-1:0] ghr_MEM,
    input  logic                branch_taken_MEM,
    input  logic                mispredict_MEM,
    output logic [31:0]         mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] RST_V = CTR_BITS'(RESET_CTR);
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [GHR_BITS-1:0] ghr_q, ghr_d, ghr_shift;
    logic [31:0]         cnt_q, cnt_d;

    logic [IDX_W-1:0] hist_if, hist_mem;
    logic [IDX_W-1:0] idx_if, idx_mem;
    logic [CTR_BITS-1:0] cur_mem;

    // History folded to index width: zero-extended or truncated
    if (GHR_BITS >= IDX_W) begin : g_hist_trunc
        assign hist_if  = ghr_q[IDX_W-1:0];
        assign hist_mem = ghr_MEM[IDX_W-1:0];
    end else begin : g_hist_ext
        assign hist_if  = {{(IDX_W-GHR_BITS){1'b0}}, ghr_q};
        assign hist_mem = {{(IDX_W-GHR_BITS){1'b0}}, ghr_MEM};
    end

    if (GHR_BITS == 1) begin : g_ghr1
        assign ghr_shift = branch_taken_MEM;
    end else begin : g_ghrn
        assign ghr_shift = {ghr_q[GHR_BITS-2:0], branch_taken_MEM};
    end

    // Read side uses live history, write side uses the fetch-time snapshot
    always_comb begin
        idx_if  = pc_IF[INDEX_LSB +: IDX_W];
        idx_mem = pc_MEM[INDEX_LSB +: IDX_W];
        if (GSHARE != 0) begin
            idx_if  = idx_if ^ hist_if;
            idx_mem = idx_mem ^ hist_mem;
        end
        cur_mem = ctr_q[idx_mem];
    end

    // Next state for table, history and mispredict counter
    always_comb begin
        ctr_d = ctr_q;
        ghr_d = ghr_q;
        cnt_d = cnt_q;
        if (update_valid_MEM) begin
            if (branch_taken_MEM) begin
                if (cur_mem != CTR_MAX) ctr_d[idx_mem] = cur_mem + 1'b1;
            end else begin
                if (cur_mem != '0) ctr_d[idx_mem] = cur_mem - 1'b1;
            end
            ghr_d = ghr_shift;
            if (mispredict_MEM && cnt_q != 32'hFFFF_FFFF) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // State registers; reset clears the whole table in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q <= '{default: RST_V};
            ghr_q <= '0;
            cnt_q <= '0;
        end else begin
            ctr_q <= ctr_d;
            ghr_q <= ghr_d;
            cnt_q <= cnt_d;
        end
    end

    assign branch_predict   = ctr_q[idx_if][CTR_BITS-1];
    assign ghr_IF           = ghr_q;
    assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_bht_gshare_predictor.sv
// Self-checking bench: directed vector table, corner sequences,
// and random traffic against an integer model of the predictor.
module tb_bht_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_IF, pc_MEM;
    logic        upd, tk, misp;
    logic [3:0]  ghr_MEM;
    logic        p0, p1;
    logic [3:0]  g0, g1;
    logic [31:0] c0, c1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bht_gshare_predictor #(
        .ENTRIES(16), .CTR_BITS(2), .INDEX_LSB(2), .GSHARE(0), .GHR_BITS(4)
    ) dut0 (
        .clk(clk), .reset(reset), .pc_IF(pc_IF), .branch_predict(p0),
        .ghr_IF(g0), .update_valid_MEM(upd), .pc_MEM(pc_MEM),
        .ghr_MEM(ghr_MEM), .branch_taken_MEM(tk), .mispredict_MEM(misp),
        .mispredict_count(c0)
    );

    bht_gshare_predictor #(
        .ENTRIES(16), .CTR_BITS(2), .INDEX_LSB(2), .GSHARE(1), .GHR_BITS(4)
    ) dut1 (
        .clk(clk), .reset(reset), .pc_IF(pc_IF), .branch_predict(p1),
        .ghr_IF(g1), .update_valid_MEM(upd), .pc_MEM(pc_MEM),
        .ghr_MEM(ghr_MEM), .branch_taken_MEM(tk), .mispredict_MEM(misp),
        .mispredict_count(c1)
    );

    typedef struct {
        logic        rst;
        logic        upd;
        logic [63:0] pc_mem;
        logic        tk;
        logic [63:0] pc_if;
        logic        exp;
    } vec_t;

    vec_t vt[$];

    // Behavioural model: plain integers per table entry
    int     mctr [2][16];
    int     mghr;
    longint mcnt;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd = 1'b0;
        tk = 1'b0;
        misp = 1'b0;
        ghr_MEM = 4'd0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle();
        repeat (n) step();
        reset = 1'b0;
    endtask

    function automatic int pidx(input logic [63:0] pc);
        return int'((pc >> 2) % 64'd16);
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 16; e++) mctr[d][e] = 1;
        mghr = 0;
        mcnt = 0;
    endtask

    task automatic m_update();
        int w;
        for (int d = 0; d < 2; d++) begin
            w = (d == 1) ? (pidx(pc_MEM) ^ int'(ghr_MEM)) : pidx(pc_MEM);
            if (tk) mctr[d][w] = (mctr[d][w] < 3) ? mctr[d][w] + 1 : 3;
            else    mctr[d][w] = (mctr[d][w] > 0) ? mctr[d][w] - 1 : 0;
        end
        mghr = (mghr * 2 + (tk ? 1 : 0)) % 16;
        if (misp && mcnt < 64'hFFFF_FFFF) mcnt = mcnt + 1;
    endtask

    initial begin
        int tseq [4];
        logic [63:0] pc_r;
        logic [31:0] pc_lo;
        int ri;
        reset = 1'b1;
        pc_IF = '0;
        pc_MEM = '0;
        idle();

        // Reset: predictions, history and count all clear
        do_reset(2);
        for (int a = 0; a <= 'hFC; a += 4) begin
            pc_IF = 64'(a);
            #1;
            chk("rst_pred0", 64'(p0), 0);
            chk("rst_pred1", 64'(p1), 0);
        end
        chk("rst_ghr0", 64'(g0), 0);
        chk("rst_ghr1", 64'(g1), 0);
        chk("rst_cnt0", 64'(c0), 0);
        chk("rst_cnt1", 64'(c1), 0);

        // Vector table on dut0: train/alias, saturation, collision
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 0});
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 1});
        vt.push_back('{0, 0, 64'h00, 0, 64'h80, 1});
        vt.push_back('{0, 0, 64'h00, 0, 64'h44, 0});
        vt.push_back('{1, 0, 64'h00, 0, 64'h40, 1});
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 0});
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 1});
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 1});
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 1});
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 1});
        vt.push_back('{0, 1, 64'h40, 0, 64'h40, 1});
        vt.push_back('{0, 1, 64'h40, 0, 64'h40, 1});
        vt.push_back('{0, 1, 64'h40, 0, 64'h40, 0});
        vt.push_back('{0, 1, 64'h40, 0, 64'h40, 0});
        vt.push_back('{0, 1, 64'h40, 0, 64'h40, 0});
        vt.push_back('{0, 1, 64'h40, 0, 64'h40, 0});
        vt.push_back('{0, 1, 64'h40, 0, 64'h40, 0});
        vt.push_back('{0, 0, 64'h00, 0, 64'h40, 0});
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 0});
        vt.push_back('{0, 0, 64'h00, 0, 64'h40, 0});
        vt.push_back('{0, 1, 64'h40, 1, 64'h40, 0});
        vt.push_back('{0, 0, 64'h00, 0, 64'h40, 1});
        do_reset(1);
        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst;
            upd = vt[i].upd;
            pc_MEM = vt[i].pc_mem;
            tk = vt[i].tk;
            misp = 1'b0;
            ghr_MEM = 4'd0;
            pc_IF = vt[i].pc_if;
            #1;
            chk($sformatf("vec%0d", i), 64'(p0), 64'(vt[i].exp));
            step();
        end
        reset = 1'b0;
        idle();

        // Gshare history build-up and snapshot-indexed training
        do_reset(2);
        tseq = '{1, 0, 1, 1};
        pc_MEM = 64'h3C;
        for (int i = 0; i < 4; i++) begin
            upd = 1'b1;
            tk = tseq[i][0];
            ghr_MEM = 4'd0;
            step();
        end
        idle();
        #1;
        chk("gs_ghr", 64'(g1), 64'hB);
        upd = 1'b1;
        tk = 1'b1;
        pc_MEM = 64'h0;
        ghr_MEM = 4'b0011;
        pc_IF = 64'h0;
        #1;
        chk("gs_pre", 64'(p1), 0);
        step();
        idle();
        chk("gs_ghr2", 64'(g1), 64'h7);
        pc_IF = 64'h10;
        #1;
        chk("gs_idx3", 64'(p1), 1);
        pc_IF = 64'h0C;
        #1;
        chk("gs_idx4", 64'(p1), 0);
        pc_IF = 64'h30;
        #1;
        chk("gs_idxB", 64'(p1), 0);
        pc_IF = 64'h20;
        #1;
        chk("gs_idxF", 64'(p1), 1);

        // Mispredict count, reset colliding with an update
        do_reset(2);
        upd = 1'b1;
        tk = 1'b1;
        misp = 1'b1;
        pc_MEM = 64'h40;
        repeat (3) step();
        idle();
        pc_IF = 64'h40;
        #1;
        chk("cnt3", 64'(c0), 3);
        chk("cnt_pred", 64'(p0), 1);
        reset = 1'b1;
        upd = 1'b1;
        tk = 1'b1;
        misp = 1'b1;
        step();
        reset = 1'b0;
        idle();
        #1;
        chk("mrst_cnt", 64'(c0), 0);
        chk("mrst_ghr", 64'(g0), 0);
        chk("mrst_pred", 64'(p0), 0);
        upd = 1'b1;
        tk = 1'b1;
        step();
        idle();
        chk("mrst_ctr", 64'(p0), 1);

        // Count saturation near the top of the range
        @(negedge clk);
        force dut0.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut0.cnt_q;
        #1;
        chk("cnt_fe", 64'(c0), 64'hFFFF_FFFE);
        upd = 1'b1;
        misp = 1'b1;
        step();
        chk("cnt_ff1", 64'(c0), 64'hFFFF_FFFF);
        step();
        chk("cnt_ff2", 64'(c0), 64'hFFFF_FFFF);
        idle();

        // Random traffic against the model
        do_reset(1);
        m_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            upd = ($urandom_range(0, 3) != 0);
            tk = 1'($urandom_range(0, 1));
            misp = 1'($urandom_range(0, 1));
            ghr_MEM = 4'($urandom_range(0, 15));
            pc_lo = $urandom;
            pc_r = {$urandom, pc_lo};
            pc_MEM = pc_r;
            pc_IF = {32'd0, $urandom};
            #1;
            ri = pidx(pc_IF);
            chk("rnd_p0", 64'(p0), 64'(mctr[0][ri] >= 2));
            chk("rnd_p1", 64'(p1), 64'(mctr[1][ri ^ mghr] >= 2));
            chk("rnd_g0", 64'(g0), 64'(mghr));
            chk("rnd_g1", 64'(g1), 64'(mghr));
            chk("rnd_c0", 64'(c0), 64'(mcnt));
            chk("rnd_c1", 64'(c1), 64'(mcnt));
            step();
            if (reset) m_reset();
            else if (upd) m_update();
        end
        reset = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
